ex_mem_req: RTL



---
 rtl/ex_mem_req.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/ex_mem_req.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ex_mem_req: EX-stage memory request issue, lane alignment and response |
// | tracking. Optional macro EX_MEM_UNALIGNED_EN enables left/right ops.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module ex_mem_req #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_wr,
  input  logic [1:0]          in_width,
  input  logic [1:0]          in_combine,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic                flush,
  output logic                exc_ades,
  output logic                exc_adel,
  output logic                data_req,
  output logic                data_wr,
  output logic [2:0]          data_size,
  output logic [DATA_W/8-1:0] data_wstrb,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [DATA_W-1:0]   data_wdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [DATA_W-1:0]   data_rdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic [2:0]          outst,
  output logic                busy
);
  localparam int C_BYTES = DATA_W / 8;
  localparam int C_OFF_W = $clog2(C_BYTES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [2:0]           r_outst, w_outst_nxt, w_outst_after;
  logic [2:0]           r_discard, w_discard_nxt;
  logic                 r_wr;
  logic [2:0]           r_size;
  logic [C_BYTES-1:0]   r_wstrb;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;

  logic [1:0]           w_width;
  logic [1:0]           w_combine;
  logic                 w_misal;
  logic                 w_in_ready;
  logic                 w_data_req;
  logic                 w_accept;
  logic                 w_issue;
  logic                 w_hs;
  logic                 w_dec;
  logic [C_OFF_W-1:0]   w_k;
  logic [2:0]           w_size;
  logic [C_BYTES-1:0]   w_strb;
  logic [DATA_W-1:0]    w_wdata;
  logic [ADDR_W-1:0]    w_baddr;
  int                   w_lo;

  // A dword op on a 32-bit bus degrades to a word op.
  always_comb begin
    w_width = in_width;
    if (DATA_W == 32 && in_width == 2'b11) w_width = 2'b10;
  end

`ifdef EX_MEM_UNALIGNED_EN
  int                   w_cb;
  int                   w_ck;
  int                   w_base;
  logic [DATA_W-1:0]    w_src;
  logic [DATA_W-1:0]    w_cdata;
  assign w_combine = in_combine;
`else
  logic                 w_unused_combine;
  assign w_combine        = 2'b00;
  assign w_unused_combine = ^in_combine;
`endif

  always_comb begin
    w_misal = 1'b0;
    if (w_combine == 2'b00) begin
      case (w_width)
        2'b01:   w_misal = in_addr[0];
        2'b10:   w_misal = |in_addr[1:0];
        2'b11:   w_misal = |in_addr[2:0];
        default: w_misal = 1'b0;
      endcase
    end
  end

  assign w_k = in_addr[C_OFF_W-1:0];

  always_comb begin
    w_lo    = int'(w_k);
    w_wdata = in_wdata << {w_k, 3'b000};
    w_baddr = in_addr;
    case (w_width)
      2'b00:   w_size = 3'd0;
      2'b01:   w_size = 3'd1;
      2'b10:   w_size = 3'd3;
      default: w_size = 3'd7;
    endcase
`ifdef EX_MEM_UNALIGNED_EN
    // Left/right ops work inside a 4- or 8-byte container that may sit at a
    // non-zero lane offset (w_base) of a wider bus.
    w_cb    = (w_width == 2'b11) ? 8 : 4;
    w_ck    = int'(in_addr[2:0]) & (w_cb - 1);
    w_base  = int'(w_k) - w_ck;
    w_src   = in_wdata;
    for (int b = 32; b < DATA_W; b++) begin
      if (w_cb == 4) w_src[b] = 1'b0;
    end
    w_cdata = '0;
    if (w_combine == 2'b01) begin
      w_size  = 3'(w_ck);
      w_lo    = w_base;
      w_cdata = w_src >> (8 * (w_cb - 1 - w_ck));
      w_baddr = in_addr & ~ADDR_W'(w_cb - 1);
    end else if (w_combine == 2'b10) begin
      w_size  = 3'(w_cb - 1 - w_ck);
      w_lo    = w_base + w_ck;
      w_cdata = w_src << (8 * w_ck);
      for (int b = 0; b < DATA_W; b++) begin
        if (b >= 8 * w_cb) w_cdata[b] = 1'b0;
      end
    end
    if (w_combine != 2'b00) w_wdata = w_cdata << (8 * w_base);
`endif
    w_strb = '0;
    if (in_wr) begin
      for (int i = 0; i < C_BYTES; i++) begin
        if (i >= w_lo && i <= w_lo + int'(w_size)) w_strb[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_data_req  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = (r_outst < 3'(MAX_OUTST)) && !flush;
        if (in_valid && w_in_ready && !w_misal) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        w_data_req = 1'b1;
        if (data_addr_ok) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept      = in_valid && w_in_ready;
  assign w_issue       = w_accept && !w_misal;
  assign w_hs          = w_data_req && data_addr_ok;
  assign w_dec         = data_data_ok && (r_outst != 3'd0);
  assign w_outst_after = r_outst - {2'b00, w_dec};
  assign w_outst_nxt   = w_outst_after + {2'b00, w_hs};

  // The flush snapshot counts the still-pending REQ; a response landing in
  // the flush cycle has already been taken out of w_outst_after.
  always_comb begin
    w_discard_nxt = r_discard;
    if (flush)
      w_discard_nxt = w_outst_after + {2'b00, (r_state == S_REQ)};
    else if (r_discard != 3'd0 && w_dec)
      w_discard_nxt = r_discard - 3'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_outst   <= 3'd0;
      r_discard <= 3'd0;
      r_wr      <= 1'b0;
      r_size    <= 3'd0;
      r_wstrb   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_outst   <= w_outst_nxt;
      r_discard <= w_discard_nxt;
      if (w_issue) begin
        r_wr    <= in_wr;
        r_size  <= w_size;
        r_wstrb <= w_strb;
        r_addr  <= w_baddr;
        r_wdata <= w_wdata;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign exc_ades   = w_accept && w_misal && in_wr && !flush;
  assign exc_adel   = w_accept && w_misal && !in_wr && !flush;
  assign data_req   = w_data_req;
  assign data_wr    = r_wr;
  assign data_size  = r_size;
  assign data_wstrb = r_wstrb;
  assign data_addr  = r_addr;
  assign data_wdata = r_wdata;
  assign resp_valid = w_dec && (r_discard == 3'd0) && !flush;
  assign resp_rdata = data_rdata;
  assign outst      = r_outst;
  assign busy       = (r_state == S_REQ) || (r_outst != 3'd0);

endmodule
`default_nettype wire
